// File: rtl/fwrisc_regfile_csr.sv
// fwrisc register file: GPRs, CSR shadow storage and cycle/instret counters, cleared by a hardware sequencer after reset.
// Optional same-cycle write-to-read forwarding: define FWRISC_REGFILE_BYPASS_EN.
//
// state    | meaning
// ST_CLEAR | zeroing storage[clr_ptr] one entry per cycle; writes ignored, reads return 0
// ST_RUN   | normal operation; counters advance, writes accepted
module fwrisc_regfile_csr #(
  parameter int              XLEN              = 32,
  parameter int              AW                = 6,
  parameter int              CNT_WIDTH         = 64,
  parameter int              ENABLE_COUNTERS   = 1,
  parameter logic [AW-1:0]   RO_BASE           = 6'h28,
  parameter logic [AW-1:0]   CSR_MCYCLE        = 6'h38,
  parameter logic [AW-1:0]   CSR_MCOUNTINHIBIT = 6'h3C
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            instr_complete,
  input  logic [AW-1:0]   ra_raddr,
  output logic [XLEN-1:0] ra_rdata,
  input  logic [AW-1:0]   rb_raddr,
  output logic [XLEN-1:0] rb_rdata,
  input  logic [AW-1:0]   rd_waddr,
  input  logic [XLEN-1:0] rd_wdata,
  input  logic            rd_wen,
  output logic            ready,
  output logic            wr_err
);

  localparam int DEPTH = 2**AW;
  localparam int HW    = CNT_WIDTH - XLEN;

  localparam logic [AW-1:0] CSR_MCYCLEH   = AW'(CSR_MCYCLE + 1);
  localparam logic [AW-1:0] CSR_MINSTRET  = AW'(CSR_MCYCLE + 2);
  localparam logic [AW-1:0] CSR_MINSTRETH = AW'(CSR_MCYCLE + 3);

  localparam logic CNT_EN = (ENABLE_COUNTERS != 0);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t                state;
  logic [AW-1:0]         clr_ptr;
  logic [XLEN-1:0]       mem [DEPTH];
  logic [CNT_WIDTH-1:0]  mcycle;
  logic [CNT_WIDTH-1:0]  minstret;
  logic                  inh_cy;
  logic                  inh_ir;

  logic                  wr_zero;
  logic                  wr_ro;
  logic                  wr_ok;
  logic                  wr_cy_lo;
  logic                  wr_cy_hi;
  logic                  wr_ir_lo;
  logic                  wr_ir_hi;
  logic                  wr_inh;
  logic                  wr_cnt;
  logic                  wr_mem;
  logic [XLEN-1:0]       ra_next;
  logic [XLEN-1:0]       rb_next;
  logic                  ra_fwd;
  logic                  rb_fwd;

  // Write classification, in priority order: address 0, read-only window, counter/inhibit, storage.
  always_comb begin
    wr_zero  = (rd_waddr == '0);
    wr_ro    = (rd_waddr[AW-1:3] == RO_BASE[AW-1:3]);
    wr_ok    = (state == ST_RUN) && rd_wen && !wr_zero && !wr_ro;
    wr_cy_lo = wr_ok && CNT_EN && (rd_waddr == CSR_MCYCLE);
    wr_cy_hi = wr_ok && CNT_EN && (rd_waddr == CSR_MCYCLEH);
    wr_ir_lo = wr_ok && CNT_EN && (rd_waddr == CSR_MINSTRET);
    wr_ir_hi = wr_ok && CNT_EN && (rd_waddr == CSR_MINSTRETH);
    wr_inh   = wr_ok && CNT_EN && (rd_waddr == CSR_MCOUNTINHIBIT);
    wr_cnt   = wr_cy_lo || wr_cy_hi || wr_ir_lo || wr_ir_hi || wr_inh;
    wr_mem   = wr_ok && !wr_cnt;
  end

  always_comb begin
    ra_next = mem[ra_raddr];
    rb_next = mem[rb_raddr];
    if (CNT_EN) begin
      if (rb_raddr == CSR_MCYCLE)
        rb_next = mcycle[XLEN-1:0];
      else if (rb_raddr == CSR_MCYCLEH)
        rb_next = XLEN'(mcycle[CNT_WIDTH-1:XLEN]);
      else if (rb_raddr == CSR_MINSTRET)
        rb_next = minstret[XLEN-1:0];
      else if (rb_raddr == CSR_MINSTRETH)
        rb_next = XLEN'(minstret[CNT_WIDTH-1:XLEN]);
      else if (rb_raddr == CSR_MCOUNTINHIBIT)
        rb_next = XLEN'({inh_ir, 1'b0, inh_cy});
    end
  end

  // Port A only ever sees storage, so it forwards storage writes only.
  always_comb begin
    ra_fwd = 1'b0;
    rb_fwd = 1'b0;
`ifdef FWRISC_REGFILE_BYPASS_EN
    ra_fwd = wr_mem && (rd_waddr == ra_raddr);
    rb_fwd = (wr_mem || wr_cnt) && (rd_waddr == rb_raddr);
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_CLEAR;
      clr_ptr  <= '0;
      ready    <= 1'b0;
      ra_rdata <= '0;
      rb_rdata <= '0;
      wr_err   <= 1'b0;
      mcycle   <= '0;
      minstret <= '0;
      inh_cy   <= 1'b0;
      inh_ir   <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_ptr  <= clr_ptr + 1'b1;
          ra_rdata <= '0;
          rb_rdata <= '0;
          wr_err   <= 1'b0;
          if (&clr_ptr) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end
        end
        ST_RUN: begin
          ra_rdata <= ra_fwd ? rd_wdata : ra_next;
          rb_rdata <= rb_fwd ? rd_wdata : rb_next;
          wr_err   <= rd_wen && wr_ro && !wr_zero;

          // A counter write replaces that counter's increment for this cycle.
          if (wr_cy_lo)
            mcycle[XLEN-1:0] <= rd_wdata;
          else if (wr_cy_hi)
            mcycle[CNT_WIDTH-1:XLEN] <= rd_wdata[HW-1:0];
          else if (CNT_EN && !inh_cy)
            mcycle <= mcycle + CNT_WIDTH'(1);

          if (wr_ir_lo)
            minstret[XLEN-1:0] <= rd_wdata;
          else if (wr_ir_hi)
            minstret[CNT_WIDTH-1:XLEN] <= rd_wdata[HW-1:0];
          else if (CNT_EN && !inh_ir && instr_complete)
            minstret <= minstret + CNT_WIDTH'(1);

          if (wr_inh) begin
            inh_cy <= rd_wdata[0];
            inh_ir <= rd_wdata[2];
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  // Storage has no reset; the clear sequencer zeroes it before any read is allowed through.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == ST_CLEAR)
        mem[clr_ptr] <= '0;
      else if (wr_mem)
        mem[rd_waddr] <= rd_wdata;
    end
  end

endmodule

// File: doc/fwrisc_regfile_csr.md
Name: fwrisc_regfile_csr

Overview:
Parametrised next-generation register file for the fwrisc core: GPRs, CSR shadow storage, and 64-bit cycle/instret counters with an inhibit CSR.
- Replaces load-time register initialisation with a hardware clear sequencer, so contents after reset are deterministic and the block is synthesis/formal-clean.
- Adds configurable depth and width, an explicit read-only CSR window with a write-error flag, and optional write-to-read bypass.
- Sits between decode/execute and writeback, as the current register file does.

Parameters:
XLEN, 32, data width of every register and read/write port.
AW, 6, address width; storage depth DEPTH = 2**AW (GPRs at 0..31, CSR shadows above).
CNT_WIDTH, 64, counter width; must satisfy XLEN < CNT_WIDTH <= 2*XLEN.
ENABLE_COUNTERS, 1, 0 removes the counters; counter addresses then read and write like plain storage.
RO_BASE, 6'h28, first address of the 8-entry read-only CSR window (RO_BASE..RO_BASE+7); must be 8-aligned.
CSR_MCYCLE, 6'h38, address of the counter low words; MCYCLEH = +1, MINSTRET = +2, MINSTRETH = +3.
CSR_MCOUNTINHIBIT, 6'h3C, address of the inhibit CSR; bit0 inhibits the cycle counter, bit2 inhibits instret.

Ports:
clock  in  1  core clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
instr_complete  in  1  one-cycle pulse per retired instruction.
ra_raddr  in  AW  read port A address; GPR/storage only.
ra_rdata  out  XLEN  registered read data, port A.
rb_raddr  in  AW  read port B address; GPR, storage or counter.
rb_rdata  out  XLEN  registered read data, port B.
rd_waddr  in  AW  write address.
rd_wdata  in  XLEN  write data.
rd_wen  in  1  write enable.
ready  out  1  1 once the clear sequence is complete.
wr_err  out  1  one-cycle pulse reporting a rejected write.

Behaviour:
- Reset values: ready=0, ra_rdata=0, rb_rdata=0, wr_err=0, counters=0, mcountinhibit=0, FSM=CLEAR, clear pointer=0.
- FSM state CLEAR:
  - Writes 0 to storage[ptr] each cycle; ptr increments.
  - When ptr==DEPTH-1 is written, transitions to RUN and asserts ready the following cycle. Total DEPTH cycles.
  - rd_wen is ignored (no write, no wr_err); ra/rb_rdata are forced to 0; counters hold 0.
- FSM state RUN:
  - Stays in RUN until reset.
  - reset in any state, including mid-CLEAR, restarts CLEAR from ptr=0.
- Writes (RUN only) are applied at posedge. Priority:
  1. rd_waddr==0: dropped silently; address 0 always reads 0.
  2. rd_waddr inside the RO window: dropped; wr_err=1 on the next cycle for exactly one cycle.
  3. Counter or inhibit address (ENABLE_COUNTERS=1): updates the counter/inhibit register, not storage.
  4. Otherwise: storage[rd_waddr] <= rd_wdata.
- Reads:
  - One-cycle latency; data reflects storage state before the same-edge write, unless the bypass feature is enabled.
  - Port B at counter addresses returns count[XLEN-1:0] or count[CNT_WIDTH-1:XLEN], zero-extended.
  - Port B at CSR_MCOUNTINHIBIT returns {XLEN-3 zeros, ir, 1'b0, cy}.
  - Port A never muxes counters.
- Counters (RUN only):
  - cycle increments every cycle unless inhibit bit0 is set.
  - instret increments on instr_complete unless inhibit bit2 is set.
  - Both wrap modulo 2**CNT_WIDTH.
  - A write to a counter word in the same cycle as an increment: the write wins; the written half takes rd_wdata, the other half is held, and there is no increment that cycle.
  - Counting resumes from the written value on the next cycle.
  - Carry out of the low word propagates into the high word in the same cycle.

Optional Feature:
FWRISC_REGFILE_BYPASS_EN:
- Defined: when rd_wen is accepted (cases 3/4) and rd_waddr equals ra_raddr or rb_raddr in the same cycle, that port's registered output takes rd_wdata instead of the old value.
- A counter write bypasses rd_wdata on port B.
- Dropped writes (address 0, RO window) are never forwarded.
- Undefined: reads return the pre-write value; software and pipeline must not rely on same-cycle forwarding.

Test Plan:
- Reset for 1 cycle, then idle -> ready stays 0 for 64 cycles and rises at cycle 65; reading every address 1..63 on both ports returns 0.
- RUN: write 0xDEADBEEF to 5, then read ra=5 and rb=5 next cycle -> both 0xDEADBEEF; write 0x1234 to 0, then read 0 -> 0.
- Write 0xFFFFFFFF to 0x2A -> wr_err pulses for 1 cycle; reading 0x2A returns 0.
- Write MCYCLE=0xFFFFFFFE, then read MCYCLEH 3 cycles later -> 0x00000001; set inhibit=0x5 -> MCYCLE frozen for 10 cycles and MINSTRET unchanged despite 4 instr_complete pulses.
- Assert reset when ptr=20 after prior writes to 40 -> CLEAR restarts, ready returns after 64 more cycles, and address 40 reads 0.
- With FWRISC_REGFILE_BYPASS_EN: write 0xA5A5A5A5 to 7 while ra_raddr=7 -> ra_rdata=0xA5A5A5A5 the next cycle. Without the macro -> the old value is returned.
